// File: rtl/factory_test_seq.sv
// factory_test_seq: self-test sequencer for the 8-bit bidirectional IO bank.
// Drives 18 fixed patterns with all output enables set, samples the loopback
// after each pattern settles, and accumulates error count, per-bit failure
// mask and first failing step. Reports pass/fail with a one-cycle done pulse.
module factory_test_seq #(
  parameter int unsigned SETTLE = 2  // DRIVE cycles per step, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] loop_in,
  output logic [7:0] pat_out,
  output logic [7:0] oe_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [7:0] bit_err,
  output logic [4:0] fail_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_FIN
  } state_e;

  localparam logic [4:0] LAST_STEP   = 5'd17;
  localparam logic [4:0] NO_FAIL     = 5'h1F;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [4:0] step_q, step_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic [7:0] bit_err_q, bit_err_d;
  logic [4:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic [7:0] pat_q, pat_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] diff;

  // Step 0 all-zero, step 1 all-one, steps 2..9 walking one, 10..17 walking zero.
  function automatic logic [7:0] pattern(input logic [4:0] s);
    logic [7:0] p;
    p = 8'h00;
    if (s == 5'd1)                      p = 8'hFF;
    else if (s >= 5'd2 && s <= 5'd9)    p = 8'h01 << (s - 5'd2);
    else if (s >= 5'd10)                p = ~(8'h01 << (s - 5'd10));
    return p;
  endfunction

  // Next-state, step sequencing, compare and result accumulation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    bit_err_d = bit_err_q;
    fail_d    = fail_q;
    pass_d    = pass_q;
    diff      = loop_in ^ pat_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_DRIVE;
          step_d    = 5'd0;
          cnt_d     = 4'd0;
          err_d     = 5'd0;
          bit_err_d = 8'h00;
          fail_d    = NO_FAIL;
          pass_d    = 1'b0;
        end
      end
      S_DRIVE: begin
        if (abort)                     state_d = S_IDLE;
        else if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
        else                           cnt_d   = cnt_q + 4'd1;
      end
      S_SAMPLE: begin
        // The loopback is only trusted here, after the pattern has settled.
        bit_err_d = bit_err_q | diff;
        if (diff != 8'h00) begin
          err_d = err_q + 5'd1;
          if (fail_q == NO_FAIL) fail_d = step_q;
        end
        if (abort) begin
          state_d = S_IDLE;
        end else if (step_q == LAST_STEP) begin
          state_d = S_FIN;
          pass_d  = (err_d == 5'd0);  // includes the final step's result
        end else begin
          state_d = S_DRIVE;
          step_d  = step_q + 5'd1;
          cnt_d   = 4'd0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pin-facing outputs are computed from the next state so they can be registered.
    busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
    pat_d  = busy_d ? pattern(step_d) : 8'h00;
    done_d = (state_d == S_FIN);
  end

  // State and output registers; reset wins over every input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= 5'd0;
      cnt_q     <= 4'd0;
      err_q     <= 5'd0;
      bit_err_q <= 8'h00;
      fail_q    <= NO_FAIL;
      pass_q    <= 1'b0;
      pat_q     <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      bit_err_q <= bit_err_d;
      fail_q    <= fail_d;
      pass_q    <= pass_d;
      pat_q     <= pat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign pat_out  = pat_q;
  assign oe_out   = {8{busy_q}};
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign bit_err  = bit_err_q;
  assign fail_idx = fail_q;

endmodule

// File: tb/tb_factory_test_seq.sv
// Directed testbench for factory_test_seq with SETTLE=2.
module tb_factory_test_seq;

  localparam int SETTLE = 2;
  localparam int PER    = SETTLE + 1;
  localparam int RUN    = 18 * PER;  // cycle of the done pulse (54)

  typedef enum int {M_IDEAL, M_STUCK3, M_STUCK0H, M_GLITCH} mode_e;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] loop_in;
  logic [7:0] pat_out, oe_out, bit_err;
  logic       busy, done, pass;
  logic [4:0] err_cnt, fail_idx;

  int checks = 0;
  int errors = 0;

  factory_test_seq #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_in(loop_in),
    .pat_out(pat_out), .oe_out(oe_out), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .bit_err(bit_err), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pattern(input int s);
    logic [7:0] one, r;
    one = 8'h01;
    if (s == 0)      r = 8'h00;
    else if (s == 1) r = 8'hFF;
    else if (s < 10) r = one << (s - 2);
    else             r = ~(one << (s - 10));
    return r;
  endfunction

  function automatic logic [7:0] loop_model(input mode_e m, input logic [7:0] p, input int c);
    logic [7:0] r;
    case (m)
      M_STUCK3:  r = p & 8'hF7;
      M_STUCK0H: r = p | 8'h01;
      M_GLITCH:  r = ((c % PER) == SETTLE) ? p : 8'hAA;
      default:   r = p;
    endcase
    return r;
  endfunction

  task automatic check_results(input string tag, input logic exp_pass, input logic [4:0] exp_err,
                               input logic [7:0] exp_bits, input logic [4:0] exp_fail);
    checks++;
    if (pass !== exp_pass) begin errors++; $display("FAIL %s pass: got %b expected %b", tag, pass, exp_pass); end
    checks++;
    if (err_cnt !== exp_err) begin errors++; $display("FAIL %s err_cnt: got %0d expected %0d", tag, err_cnt, exp_err); end
    checks++;
    if (bit_err !== exp_bits) begin errors++; $display("FAIL %s bit_err: got %h expected %h", tag, bit_err, exp_bits); end
    checks++;
    if (fail_idx !== exp_fail) begin errors++; $display("FAIL %s fail_idx: got %h expected %h", tag, fail_idx, exp_fail); end
  endtask

  // Pulse start so that the next negedge falls in cycle 0 of the run.
  task automatic begin_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Step through run cycles first..last, checking pin outputs against the expected schedule.
  task automatic run_cycles(input mode_e m, input int first, input int last, input int sp_a, input int sp_b);
    for (int c = first; c <= last; c++) begin
      logic       exp_busy, exp_done;
      logic [7:0] exp_pat;
      exp_busy = (c < RUN);
      exp_done = (c == RUN);
      exp_pat  = exp_busy ? pattern(c / PER) : 8'h00;
      checks++;
      if (busy !== exp_busy) begin errors++; $display("FAIL busy c%0d: got %b expected %b", c, busy, exp_busy); end
      checks++;
      if (oe_out !== {8{exp_busy}}) begin errors++; $display("FAIL oe_out c%0d: got %h expected %h", c, oe_out, {8{exp_busy}}); end
      checks++;
      if (pat_out !== exp_pat) begin errors++; $display("FAIL pat_out c%0d: got %h expected %h", c, pat_out, exp_pat); end
      checks++;
      if (done !== exp_done) begin errors++; $display("FAIL done c%0d: got %b expected %b", c, done, exp_done); end
      if (c == 0) check_results("cleared_at_start", 1'b0, 5'd0, 8'h00, 5'h1F);
      loop_in = exp_busy ? loop_model(m, exp_pat, c) : 8'h00;
      start   = (c == sp_a) || (c == sp_b);
      @(negedge clk);
    end
    start   = 1'b0;
    loop_in = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop_in = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || oe_out !== 8'h00 || pat_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_pins: got busy=%b done=%b oe=%h pat=%h expected 0 0 00 00", busy, done, oe_out, pat_out);
    end
    check_results("reset", 1'b0, 5'd0, 8'h00, 5'h1F);
  endtask

  task automatic test_ideal();
    begin_run();
    run_cycles(M_IDEAL, 0, RUN + 1, -1, -1);
    check_results("ideal", 1'b1, 5'd0, 8'h00, 5'h1F);
  endtask

  task automatic test_stuck_bit3();
    begin_run();
    run_cycles(M_STUCK3, 0, 4, -1, -1);
    check_results("stuck3_c5", 1'b0, 5'd0, 8'h00, 5'h1F);
    run_cycles(M_STUCK3, 5, 5, -1, -1);
    check_results("stuck3_c6", 1'b0, 5'd1, 8'h08, 5'd1);
    run_cycles(M_STUCK3, 6, RUN + 1, -1, -1);
    check_results("stuck3", 1'b0, 5'd9, 8'h08, 5'd1);
  endtask

  task automatic test_glitch();
    begin_run();
    run_cycles(M_GLITCH, 0, RUN + 1, -1, -1);
    check_results("glitch", 1'b1, 5'd0, 8'h00, 5'h1F);
  endtask

  task automatic test_abort();
    begin_run();
    run_cycles(M_STUCK0H, 0, 9, -1, -1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_c10_busy: got %b expected 1", busy); end
    abort   = 1'b1;
    loop_in = loop_model(M_STUCK0H, pattern(3), 10);
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || oe_out !== 8'h00 || pat_out !== 8'h00) begin
      errors++;
      $display("FAIL abort_c11: got busy=%b oe=%h pat=%h expected 0 00 00", busy, oe_out, pat_out);
    end
    for (int i = 0; i < RUN; i++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle c%0d: got done=%b busy=%b expected 0 0", i + 11, done, busy);
      end
      @(negedge clk);
    end
    check_results("abort", 1'b0, 5'd1, 8'h01, 5'd0);
    // start together with abort in IDLE does nothing
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy: got %b expected 0", busy); end
    check_results("start_abort", 1'b0, 5'd1, 8'h01, 5'd0);
  endtask

  task automatic test_back_to_back();
    begin_run();
    run_cycles(M_STUCK3, 0, RUN, 5, RUN);
    // cycle 55: IDLE, results of the first run held
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_c55: got busy=%b done=%b expected 0 0", busy, done);
    end
    check_results("b2b_first", 1'b0, 5'd9, 8'h08, 5'd1);
    begin_run();
    run_cycles(M_IDEAL, 0, RUN + 1, -1, -1);
    check_results("b2b_second", 1'b1, 5'd0, 8'h00, 5'h1F);
  endtask

  task automatic test_reset_midrun();
    begin_run();
    run_cycles(M_STUCK3, 0, 19, -1, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || oe_out !== 8'h00 || pat_out !== 8'h00) begin
      errors++;
      $display("FAIL midrun_reset_pins: got busy=%b done=%b oe=%h pat=%h expected 0 0 00 00", busy, done, oe_out, pat_out);
    end
    check_results("midrun_reset", 1'b0, 5'd0, 8'h00, 5'h1F);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_idle: got busy=%b expected 0", busy); end
    begin_run();
    run_cycles(M_IDEAL, 0, RUN + 1, -1, -1);
    check_results("after_reset_run", 1'b1, 5'd0, 8'h00, 5'h1F);
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck_bit3();
    test_glitch();
    test_abort();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/factory_test_seq.md
# factory_test_seq

Self-test sequencer for the 8-bit bidirectional IO bank of the factory test design. On a start pulse it drives a fixed series of 18 test patterns onto the IO output path with all output enables set. After each pattern settles, it samples the loopback input and compares it against the pattern. It accumulates an error count, a per-bit failure mask and the first failing step, then reports pass/fail with a one-cycle done pulse. It sits between the top-level `ui_in` control bits and the `uio_*` pins, replacing the free-running counter drive while a test runs.

## Interface

Parameters:
- `SETTLE`, default 2: DRIVE cycles per step before sampling. Legal range 1..15; 4-bit internal counter.

Ports:
- `clk` in 1: system clock; everything on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: begin a test run; sampled in IDLE only.
- `abort` in 1: terminate a run; sampled in DRIVE/SAMPLE.
- `loop_in` in 8: loopback sample of IO pins (`uio_in`).
- `pat_out` out 8: pattern to IO output path (`uio_out`).
- `oe_out` out 8: IO output enables (`uio_oe`); 8'hFF while busy, else 8'h00.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at normal completion.
- `pass` out 1: last completed run had zero mismatches.
- `err_cnt` out 5: number of mismatching steps in current/last run.
- `bit_err` out 8: OR of (`loop_in` XOR `pat_out`) over all sampled steps.
- `fail_idx` out 5: index of first mismatching step; 5'h1F if none.

## Operation

- Pattern table, step s = 0..17:
  - s=0: 8'h00.
  - s=1: 8'hFF.
  - s=2..9: walking one, `8'h01 << (s-2)`.
  - s=10..17: walking zero, `~(8'h01 << (s-10))`.
- States:
  - IDLE: `busy`=0, `oe_out`=0, `pat_out`=0.
  - DRIVE: `busy`=1, `oe_out`=FF, `pat_out`=pattern(step); lasts SETTLE cycles.
  - SAMPLE: same drive as DRIVE, 1 cycle; compare performed.
  - FIN: 1 cycle; `done`=1, `busy`=0, `oe_out`=0; then back to IDLE.
- Transitions:
  - IDLE + `start` & !`abort` → DRIVE, step=0. On this edge clear `err_cnt`=0, `bit_err`=0, `fail_idx`=1F, `pass`=0.
  - DRIVE → SAMPLE after SETTLE cycles.
  - SAMPLE → DRIVE with step+1 if step<17, else FIN.
  - Any busy state + `abort` → IDLE at next edge. No `done`, `pass` stays 0, partial `err_cnt`/`bit_err`/`fail_idx` retained.
- Compare, SAMPLE cycle only:
  - diff = `loop_in` ^ `pat_out`.
  - If diff≠0: `err_cnt` += 1 (max 18, no wrap possible); `fail_idx` = step if still 1F.
  - `bit_err` |= diff.
  - `loop_in` is ignored in all other states.
- FIN: `pass` ← (`err_cnt` == 0), where `err_cnt` includes step 17's result. Results hold until next start.
- `start` while busy or in FIN: ignored; no queuing.
- `start` and `abort` together in IDLE: no action.

## Timing

- Reset values: `pat_out`=0, `oe_out`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `bit_err`=0, `fail_idx`=1F. State=IDLE, step=0.
- `rst` dominates all inputs. Reset mid-run drops `oe_out` to 0 at the same edge.
- All outputs are registered; no combinational path from inputs to outputs.
- Cycle numbering: cycle 0 is the first cycle with `busy`=1 (the cycle after the edge that samples `start`).
- Step s:
  - Drives during cycles s·(SETTLE+1) .. s·(SETTLE+1)+SETTLE.
  - Samples in the last of those cycles.
  - Compare result is visible in `err_cnt`/`bit_err`/`fail_idx` one cycle later.
- `done`/`pass` are valid in cycle 18·(SETTLE+1). For SETTLE=2 that is cycle 54, with `busy` high for cycles 0..53.
- Earliest next start: the `start` edge in the cycle after FIN (back-to-back runs are separated by one IDLE cycle).
- Abort sampled in cycle n: cycle n+1 has `busy`=0 and `oe_out`=0.

## Test plan

- Ideal loopback, SETTLE=2 (`loop_in`=`pat_out`), pulse `start` → `busy` for cycles 0..53; `done`=1 only in cycle 54. Then `pass`=1, `err_cnt`=0, `bit_err`=00, `fail_idx`=1F.
- Bit 3 stuck low (`loop_in`=`pat_out`&F7) → `err_cnt`=9 (steps 1, 5, 10–12, 14–17), `fail_idx`=1, `bit_err`=08, `pass`=0.
- Glitch `loop_in`=AA during every DRIVE cycle, correct value in SAMPLE cycles → `pass`=1, `err_cnt`=0 (confirms sample-only compare).
- `abort` in cycle 10 with bit 0 stuck high → cycle 11 has `busy`=0 and `oe_out`=0. No `done` pulse, `pass`=0, `err_cnt`=1 (step 0 failed), `fail_idx`=0.
- `start` pulsed in cycles 5 and 54 → no restart, `done` at cycle 54 as normal. A new `start` in cycle 55 begins a new run with results cleared.
- `rst` asserted in cycle 20, then released → all outputs at reset values next cycle, state IDLE. A subsequent `start` runs a full clean test with `pass`=1.
